dma_fifo_drain: RTL and testbench

//  Downstream stage of the 512-byte one-shot DMA fifo. Pops bytes from the fifo as they

---
 rtl/dma_fifo_drain.sv | 134 +++++++++++++
 tb/tb_dma_fifo_drain.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_fifo_drain.sv
// dma_fifo_drain: drains a one-shot block fifo into memory, one DMA bus write per byte at
// consecutive addresses from a loaded start address; re-inits the fifo and pulses done at block end.
module dma_fifo_drain #(
   parameter int ADDR_WIDTH = 21,
   parameter int BLK_LOG2   = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] addr_init,
   output logic                  busy,
   output logic                  done,
   input  logic                  fifo_empty,
   input  logic [7:0]            fifo_rd,
   output logic                  fifo_rd_stb,
   output logic                  fifo_init,
   output logic                  dma_req,
   output logic [ADDR_WIDTH-1:0] dma_addr,
   output logic [7:0]            dma_wd,
   input  logic                  dma_ack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_FETCH,
      S_REQ,
      S_CLR,
      S_DONE
   } state_t;

   state_t                state, state_n;
   logic [BLK_LOG2:0]     count, count_n;
   logic                  busy_n, done_n, stb_n, init_n, req_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [7:0]            wd_n;

   // Every output is a register; the comb block below only computes their next values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         count       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         fifo_rd_stb <= 1'b0;
         fifo_init   <= 1'b0;
         dma_req     <= 1'b0;
         dma_addr    <= '0;
         dma_wd      <= '0;
      end else begin
         state       <= state_n;
         count       <= count_n;
         busy        <= busy_n;
         done        <= done_n;
         fifo_rd_stb <= stb_n;
         fifo_init   <= init_n;
         dma_req     <= req_n;
         dma_addr    <= addr_n;
         dma_wd      <= wd_n;
      end
   end

   always_comb begin
      state_n = state;
      count_n = count;
      busy_n  = busy;
      done_n  = 1'b0;
      stb_n   = 1'b0;
      init_n  = 1'b0;
      req_n   = dma_req;
      addr_n  = dma_addr;
      wd_n    = dma_wd;
      case (state)
         S_IDLE: begin
            if (start) begin
               addr_n  = addr_init;
               count_n = '0;
               busy_n  = 1'b1;
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (abort) begin
               init_n  = 1'b1;
               state_n = S_CLR;
            end else if (!fifo_empty) begin
               state_n = S_FETCH;
            end
         end
         S_FETCH: begin
            // The empty flag seen in WAIT may predate the last strobe; re-check it here.
            if (abort) begin
               init_n  = 1'b1;
               state_n = S_CLR;
            end else if (fifo_empty) begin
               state_n = S_WAIT;
            end else begin
               wd_n    = fifo_rd;
               req_n   = 1'b1;
               state_n = S_REQ;
            end
         end
         S_REQ: begin
            if (dma_ack) begin
               req_n   = 1'b0;
               stb_n   = 1'b1;
               addr_n  = dma_addr + 1'b1;
               count_n = count + 1'b1;
               if (abort || count_n[BLK_LOG2]) begin
                  init_n  = 1'b1;
                  state_n = S_CLR;
               end else begin
                  state_n = S_WAIT;
               end
            end else if (abort) begin
               req_n   = 1'b0;
               init_n  = 1'b1;
               state_n = S_CLR;
            end
         end
         S_CLR: begin
            done_n  = 1'b1;
            state_n = S_DONE;
         end
         S_DONE: begin
            busy_n  = 1'b0;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dma_fifo_drain.sv
// tb_dma_fifo_drain: randomized bench with an upstream fifo model, a DMA ack responder and a
// block-level reference (write i goes to start+i with the i-th byte pushed into the fifo).
module tb_dma_fifo_drain;
   localparam int AW  = 21;
   localparam int BLK = 512;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] addr_init = '0;
   logic          busy, done, fifo_empty, fifo_rd_stb, fifo_init, dma_req;
   logic [7:0]    fifo_rd, dma_wd;
   logic [AW-1:0] dma_addr;
   logic          dma_ack = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dma_fifo_drain #(.ADDR_WIDTH(AW), .BLK_LOG2(9)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .addr_init(addr_init),
      .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
      .fifo_rd_stb(fifo_rd_stb), .fifo_init(fifo_init), .dma_req(dma_req),
      .dma_addr(dma_addr), .dma_wd(dma_wd), .dma_ack(dma_ack)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Upstream fifo: synchronous read addressed by the next read pointer, write-first.
   logic [7:0] fmem [0:1023];
   logic [9:0] wptr, rptr, rptr_nx;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'd0;
   assign rptr_nx    = rptr + {9'd0, fifo_rd_stb};
   assign fifo_empty = (wptr == rptr);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr    <= '0;
         rptr    <= '0;
         fifo_rd <= '0;
      end else if (fifo_init) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) begin
            fmem[wptr] <= wr_data;
            wptr       <= wptr + 10'd1;
         end
         rptr    <= rptr_nx;
         fifo_rd <= (wr_en && wptr == rptr_nx) ? wr_data : fmem[rptr_nx];
      end
   end

   // Feeder: pushes blk_data[0..feed_total-1], feed_gap idle cycles between bytes (<0: random).
   logic [7:0] blk_data [0:BLK-1];
   int         feed_total = BLK;
   int         feed_gap = 0;
   logic       feed_busy = 1'b0;
   event       feed_ev;

   initial begin : feeder
      int g;
      forever begin
         @(feed_ev);
         feed_busy = 1'b1;
         for (int i = 0; i < feed_total; i++) begin
            g = (feed_gap < 0) ? int'($urandom_range(5, 0)) : feed_gap;
            repeat (g) begin @(posedge clk); #1; wr_en = 1'b0; end
            @(posedge clk); #1; wr_en = 1'b1; wr_data = blk_data[i];
         end
         @(posedge clk); #1; wr_en = 1'b0;
         feed_busy = 1'b0;
      end
   end

   // DMA responder: ack after ack_dly waiting cycles (<0: random), optional spurious acks
   // while req is low, abort either right after ack #abort_k (mode 1) or with it (mode 2).
   int ack_dly = 0;
   bit spurious = 1'b0;
   int abort_mode = 0;
   int abort_k = 100;

   initial begin : responder
      int wcnt, acks, cur_dly;
      bit adone;
      wcnt = 0; acks = 0; cur_dly = 0; adone = 1'b0;
      forever begin
         @(posedge clk); #1;
         dma_ack = 1'b0;
         abort   = 1'b0;
         if (!busy) begin
            acks = 0; adone = 1'b0; wcnt = 0;
            cur_dly = (ack_dly < 0) ? int'($urandom_range(4, 0)) : ack_dly;
         end
         if (dma_req) begin
            if (wcnt == cur_dly) begin
               dma_ack = 1'b1;
               wcnt    = 0;
               if (abort_mode == 2 && acks == abort_k && !adone) begin abort = 1'b1; adone = 1'b1; end
               acks++;
               cur_dly = (ack_dly < 0) ? int'($urandom_range(4, 0)) : ack_dly;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt = 0;
            if (abort_mode == 1 && acks == abort_k && !adone && busy) begin abort = 1'b1; adone = 1'b1; end
            if (spurious && $urandom_range(3, 0) == 0) dma_ack = 1'b1;
         end
      end
   end

   // Monitor, sampled on the falling edge; per-block counters clear on an accepted start.
   int            cyc = 0, n_wr = 0, n_stb = 0, n_stb_empty = 0, n_init = 0, n_done = 0;
   int            n_unstable = 0, n_early = 0, init_cyc = 0, done_cyc = 0;
   logic          busy_at_done = 1'b0;
   logic [AW-1:0] wr_addr [0:BLK-1];
   logic [7:0]    wr_byte [0:BLK-1];
   logic          p_req = 1'b0, p_ack = 1'b0;
   logic [AW-1:0] p_addr = '0;
   logic [7:0]    p_wd = '0;

   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (start && !busy) begin
            n_wr = 0; n_stb = 0; n_stb_empty = 0; n_init = 0; n_done = 0;
            n_unstable = 0; n_early = 0; init_cyc = 0; done_cyc = 0; busy_at_done = 1'b0;
         end
         if (rst_n) begin
            if (dma_req && dma_ack) begin
               if (n_wr < BLK) begin wr_addr[n_wr] = dma_addr; wr_byte[n_wr] = dma_wd; end
               n_wr++;
            end
            if (fifo_rd_stb) begin
               n_stb++;
               if (fifo_empty) n_stb_empty++;
            end
            if (fifo_init) begin n_init++; init_cyc = cyc; end
            if (done) begin n_done++; done_cyc = cyc; busy_at_done = busy; end
            if (dma_req && p_req && !p_ack && (dma_addr !== p_addr || dma_wd !== p_wd)) n_unstable++;
            if (dma_req && !p_req && fifo_empty) n_early++;
         end
         p_req = dma_req; p_ack = dma_ack; p_addr = dma_addr; p_wd = dma_wd;
      end
   end

   task automatic prefill(input string nm);
      int t;
      feed_total = BLK;
      feed_gap   = 0;
      -> feed_ev;
      @(posedge clk);
      t = 0;
      while (feed_busy && t < 2000) begin @(posedge clk); t++; end
      chk({nm, ".prefill_done"}, 32'(feed_busy), 0);
   endtask

   task automatic pulse_start(input logic [AW-1:0] a);
      @(posedge clk); #1; start = 1'b1; addr_init = a;
      @(posedge clk); #1; start = 1'b0; addr_init = AW'($urandom);
   endtask

   task automatic run_block(input logic [AW-1:0] a, input int dly, input int gap, input bit pre,
                            input bit pattern, input bit spur, input int amode, input int exp_n,
                            input bit mid_start, input string nm);
      int            t, f0;
      logic [AW-1:0] ea;
      for (int i = 0; i < BLK; i++) blk_data[i] = pattern ? 8'(i) : 8'($urandom);
      ack_dly = dly; spurious = spur; abort_mode = amode; abort_k = 100;
      if (pre) prefill(nm);
      pulse_start(a);
      if (!pre) begin feed_total = BLK; feed_gap = gap; -> feed_ev; end
      if (mid_start) begin
         repeat (40) @(posedge clk);
         #1; start = 1'b1; addr_init = ~a;
         @(posedge clk); #1; start = 1'b0;
      end
      t = 0;
      while (n_done == 0 && t < 20000) begin @(posedge clk); t++; end
      chk({nm, ".done_seen"}, 32'(n_done != 0), 1);
      repeat (3) @(posedge clk);
      #1;
      chk({nm, ".writes"}, n_wr, exp_n);
      f0 = n_fail;
      for (int i = 0; i < exp_n && i < BLK; i++) begin
         ea = a + AW'(i);
         chk($sformatf("%s.addr[%0d]", nm, i), 32'(wr_addr[i]), 32'(ea));
         chk($sformatf("%s.data[%0d]", nm, i), 32'(wr_byte[i]), 32'(blk_data[i]));
         if (n_fail != f0) break;
      end
      chk({nm, ".rd_stb"}, n_stb, exp_n);
      chk({nm, ".init_pulses"}, n_init, 1);
      chk({nm, ".done_pulses"}, n_done, 1);
      chk({nm, ".done_after_init"}, done_cyc - init_cyc, 1);
      chk({nm, ".busy_at_done"}, 32'(busy_at_done), 1);
      chk({nm, ".busy_after"}, 32'(busy), 0);
      chk({nm, ".stb_when_empty"}, n_stb_empty, 0);
      chk({nm, ".req_unstable"}, n_unstable, 0);
      chk({nm, ".req_before_data"}, n_early, 0);
      ea = a + AW'(exp_n);
      chk({nm, ".final_addr"}, 32'(dma_addr), 32'(ea));
   endtask

   initial begin : main
      int t;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(done), 0);
      chk("rst.outs", 32'({fifo_rd_stb, fifo_init, dma_req}), 0);
      chk("rst.addr_wd", 32'({dma_addr, dma_wd}), 0);
      @(negedge clk); #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle.busy", 32'(busy), 0);

      run_block(21'h1F000, 1, 0, 1'b1, 1'b1, 1'b0, 0, 512, 1'b0, "t1_prefill");
      run_block(AW'($urandom), 0, 20, 1'b0, 1'b0, 1'b0, 0, 512, 1'b0, "t2_slow_feed");
      run_block(AW'($urandom), 7, 0, 1'b1, 1'b0, 1'b1, 0, 512, 1'b0, "t3_slow_ack");
      run_block(21'h1FFFF0, -1, -1, 1'b0, 1'b0, 1'b0, 0, 512, 1'b1, "t4_wrap");
      run_block(AW'($urandom), 0, 0, 1'b1, 1'b0, 1'b0, 1, 100, 1'b0, "t5_abort");
      run_block(AW'($urandom), 2, 0, 1'b1, 1'b0, 1'b0, 2, 101, 1'b0, "t5_abort_ack");
      run_block(AW'($urandom), -1, 0, 1'b1, 1'b0, 1'b1, 0, 512, 1'b0, "t5_clean");

      // Reset while a request is outstanding.
      for (int i = 0; i < BLK; i++) blk_data[i] = 8'($urandom);
      ack_dly = 3; spurious = 1'b0; abort_mode = 0;
      prefill("t6");
      pulse_start(21'h0ABCDE);
      t = 0;
      do begin @(negedge clk); t++; end while (!(n_wr >= 10 && dma_req) && t < 2000);
      chk("t6.req_seen", 32'(dma_req), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6.rst_busy", 32'(busy), 0);
      chk("t6.rst_req", 32'(dma_req), 0);
      chk("t6.rst_pulses", 32'({done, fifo_rd_stb, fifo_init}), 0);
      chk("t6.rst_addr_wd", 32'({dma_addr, dma_wd}), 0);
      @(negedge clk); #2 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("t6.idle_busy", 32'(busy), 0);
      chk("t6.no_init", n_init, 0);
      chk("t6.no_done", n_done, 0);
      run_block(AW'($urandom), -1, -1, 1'b0, 1'b0, 1'b1, 0, 512, 1'b0, "t6_recover");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
